// File: rtl/bulls_cows_round_ctrl_pkg.sv
// Shared encodings for the Bulls & Cows round controller: FSM states,
// comparator result codes and the BCD digit limit.
package bulls_cows_pkg;

  typedef enum logic [2:0] {
    ST_SECRET = 3'b000,
    ST_GUESS  = 3'b001,
    ST_CHECK  = 3'b010,
    ST_WIN    = 3'b011,
    ST_LOSE   = 3'b100
  } state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_ONE  = 2'b01;
  localparam logic [1:0] RES_BOTH = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Both nibbles must be decimal digits for a switch value to be accepted.
  function automatic logic isBcd(input logic [7:0] value);
    return (value[7:4] <= BCD_MAX) && (value[3:0] <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bulls_cows_round_ctrl_if.sv
// Player/comparator-facing signal bundle of the round controller.
interface bulls_cows_round_ctrl_if;

  logic [7:0] sw_i;
  logic       enter_i;
  logic       clear_i;
  logic [1:0] result_i;
  logic [7:0] secret_o;
  logic [7:0] guess_o;
  logic       cmp_valid_o;
  logic [3:0] attempts_o;
  logic [2:0] state_o;
  logic       win_o;
  logic       lose_o;

  modport master (
    output sw_i, enter_i, clear_i, result_i,
    input  secret_o, guess_o, cmp_valid_o, attempts_o, state_o, win_o, lose_o
  );

  modport slave (
    input  sw_i, enter_i, clear_i, result_i,
    output secret_o, guess_o, cmp_valid_o, attempts_o, state_o, win_o, lose_o
  );

endinterface

// File: rtl/bulls_cows_round_ctrl_btn_sync_edge.sv
// Two-flop synchronizer plus history flop turning a raw button into a
// single-cycle press pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_hist;
  logic       r_armed;
  logic [1:0] r_warm;

  // r_armed only sets once a genuinely released level has passed the
  // synchronizer, so a button held across reset release stays silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
      r_armed <= 1'b0;
      r_warm  <= 2'b00;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_warm  <= {r_warm[0], 1'b1};
      if (r_warm[1] && !r_sync2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_pulse = r_sync2 & ~r_hist & r_armed;

endmodule

// File: rtl/bulls_cows_round_ctrl.sv
// Round controller for a two-digit Bulls & Cows game: latches the secret and
// each guess, strobes the downstream comparator and tracks attempts/outcome.
module bulls_cows_round_ctrl
  import bulls_cows_pkg::*;
#(
  parameter int MAX_ATTEMPTS = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  bulls_cows_round_ctrl_if.slave  bus
);

  localparam logic [3:0] MAX_A = 4'(MAX_ATTEMPTS);

  logic       w_enterPulse;
  logic       w_clearPulse;
  logic [3:0] w_nextAttempts;

  state_t     r_state;
  logic [7:0] r_secret;
  logic [7:0] r_guess;
  logic [3:0] r_attempts;
  logic       r_cmpValid;
  logic       r_win;
  logic       r_lose;

  btn_sync_edge u_enterSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.enter_i),
    .o_pulse (w_enterPulse)
  );

  btn_sync_edge u_clearSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.clear_i),
    .o_pulse (w_clearPulse)
  );

  assign w_nextAttempts = r_attempts + 4'd1;

  // Clear takes priority over everything; CHECK ignores enter so presses
  // arriving during the comparator cycle are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_SECRET;
      r_secret   <= 8'h00;
      r_guess    <= 8'h00;
      r_attempts <= 4'd0;
      r_cmpValid <= 1'b0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
    end else if (w_clearPulse) begin
      r_state    <= ST_SECRET;
      r_secret   <= 8'h00;
      r_guess    <= 8'h00;
      r_attempts <= 4'd0;
      r_cmpValid <= 1'b0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
    end else begin
      case (r_state)
        ST_SECRET: begin
          if (w_enterPulse && isBcd(bus.sw_i)) begin
            r_secret   <= bus.sw_i;
            r_attempts <= 4'd0;
            r_state    <= ST_GUESS;
          end
        end
        ST_GUESS: begin
          if (w_enterPulse && isBcd(bus.sw_i)) begin
            r_guess    <= bus.sw_i;
            r_cmpValid <= 1'b1;
            r_state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_cmpValid <= 1'b0;
          r_attempts <= w_nextAttempts;
          if (bus.result_i == RES_BOTH) begin
            r_win   <= 1'b1;
            r_state <= ST_WIN;
          end else if (w_nextAttempts == MAX_A) begin
            r_lose  <= 1'b1;
            r_state <= ST_LOSE;
          end else begin
            r_state <= ST_GUESS;
          end
        end
        ST_WIN, ST_LOSE: begin
          if (w_enterPulse) begin
            r_guess    <= 8'h00;
            r_attempts <= 4'd0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
            r_state    <= ST_SECRET;
          end
        end
        default: begin
          r_cmpValid <= 1'b0;
          r_win      <= 1'b0;
          r_lose     <= 1'b0;
          r_state    <= ST_SECRET;
        end
      endcase
    end
  end

  assign bus.secret_o    = r_secret;
  assign bus.guess_o     = r_guess;
  assign bus.cmp_valid_o = r_cmpValid;
  assign bus.attempts_o  = r_attempts;
  assign bus.state_o     = r_state;
  assign bus.win_o       = r_win;
  assign bus.lose_o      = r_lose;

endmodule

// File: tb/tb_bulls_cows_round_ctrl.sv
// Self-checking bench for bulls_cows_round_ctrl: table-driven guess rounds,
// a scoreboard matched against comparator strobes, and hand-written corners.
module tb_bulls_cows_round_ctrl;

  localparam logic [2:0] S_SECRET = 3'd0;
  localparam logic [2:0] S_GUESS  = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_WIN    = 3'd3;
  localparam logic [2:0] S_LOSE   = 3'd4;

  typedef struct {
    logic [7:0] guess;
    logic [3:0] attempts;
    logic [2:0] state;
    logic       win;
    logic       lose;
  } expT;

  typedef struct {
    logic [7:0] sw;
    logic [1:0] res;
    logic [3:0] expAttempts;
    logic [2:0] expState;
  } vecT;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errCount;
  int   cmpCount;
  logic ignoreCmp;
  expT  sbQ[$];
  vecT  vecs[8];

  bulls_cows_round_ctrl_if bus ();

  bulls_cows_round_ctrl #(.MAX_ATTEMPTS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] secret, input logic [7:0] guess,
                          input logic [3:0] att, input logic [2:0] state,
                          input logic win, input logic lose);
    checkOutput($sformatf("%s.secret", tag), 32'(bus.secret_o), 32'(secret));
    checkOutput($sformatf("%s.guess", tag), 32'(bus.guess_o), 32'(guess));
    checkOutput($sformatf("%s.attempts", tag), 32'(bus.attempts_o), 32'(att));
    checkOutput($sformatf("%s.state", tag), 32'(bus.state_o), 32'(state));
    checkOutput($sformatf("%s.win", tag), 32'(bus.win_o), 32'(win));
    checkOutput($sformatf("%s.lose", tag), 32'(bus.lose_o), 32'(lose));
  endtask

  // One full press: hold long enough to pass the synchronizer, then release
  // long enough for the history flop to see the button low again.
  task automatic applyStimulus(input logic [7:0] sw);
    bus.sw_i    = sw;
    bus.enter_i = 1'b1;
    repeat (4) @(negedge clk);
    bus.enter_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pushExp(input logic [7:0] g, input logic [3:0] a, input logic [2:0] s);
    expT e;
    e.guess    = g;
    e.attempts = a;
    e.state    = s;
    e.win      = (s == S_WIN);
    e.lose     = (s == S_LOSE);
    sbQ.push_back(e);
  endtask

  // Scoreboard side: each comparator strobe pops one expectation; the guess
  // is checked during CHECK and the exit results one cycle later.
  expT  pend;
  logic pendValid;
  initial pendValid = 1'b0;
  always @(negedge clk) begin
    if (pendValid) begin
      checkOutput("sb.attempts", 32'(bus.attempts_o), 32'(pend.attempts));
      checkOutput("sb.state", 32'(bus.state_o), 32'(pend.state));
      checkOutput("sb.win", 32'(bus.win_o), 32'(pend.win));
      checkOutput("sb.lose", 32'(bus.lose_o), 32'(pend.lose));
      checkOutput("sb.cmpOneCycle", 32'(bus.cmp_valid_o), 32'd0);
      pendValid = 1'b0;
    end else if (bus.cmp_valid_o === 1'b1) begin
      cmpCount++;
      if (!ignoreCmp) begin
        if (sbQ.size() == 0) begin
          checkCount++;
          errCount++;
          $display("[TB] FAIL sb.unexpectedCheck: got strobe with guess %0h, required none", bus.guess_o);
        end else begin
          pend = sbQ.pop_front();
          checkOutput("sb.guess", 32'(bus.guess_o), 32'(pend.guess));
          pendValid = 1'b1;
        end
      end
    end
  end

  initial begin
    int   cmpBefore;
    logic found;

    vecs[0] = '{8'h13, 2'b00, 4'd1, S_GUESS};
    vecs[1] = '{8'h24, 2'b01, 4'd2, S_GUESS};
    vecs[2] = '{8'h40, 2'b10, 4'd3, S_GUESS};
    vecs[3] = '{8'h02, 2'b01, 4'd4, S_GUESS};
    vecs[4] = '{8'h99, 2'b00, 4'd5, S_GUESS};
    vecs[5] = '{8'h00, 2'b10, 4'd6, S_GUESS};
    vecs[6] = '{8'h41, 2'b01, 4'd7, S_GUESS};
    vecs[7] = '{8'h42, 2'b11, 4'd8, S_WIN};

    checkCount   = 0;
    errCount     = 0;
    cmpCount     = 0;
    ignoreCmp    = 1'b0;
    rst_n        = 1'b0;
    bus.sw_i     = 8'h00;
    bus.enter_i  = 1'b0;
    bus.clear_i  = 1'b0;
    bus.result_i = 2'b00;

    #3;
    checkAll("reset", 8'h00, 8'h00, 4'd0, S_SECRET, 1'b0, 1'b0);
    checkOutput("reset.cmpValid", 32'(bus.cmp_valid_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    $display("[TB] invalid BCD secret is ignored");
    applyStimulus(8'h4A);
    checkAll("badSecret", 8'h00, 8'h00, 4'd0, S_SECRET, 1'b0, 1'b0);

    $display("[TB] first-guess win");
    applyStimulus(8'h42);
    checkAll("secretLoad", 8'h42, 8'h00, 4'd0, S_GUESS, 1'b0, 1'b0);
    cmpBefore    = cmpCount;
    bus.result_i = 2'b11;
    pushExp(8'h42, 4'd1, S_WIN);
    applyStimulus(8'h42);
    checkOutput("quickWin.cmpPulses", 32'(cmpCount - cmpBefore), 32'd1);
    checkAll("quickWin", 8'h42, 8'h42, 4'd1, S_WIN, 1'b1, 1'b0);
    applyStimulus(8'h00);
    checkAll("winExit", 8'h42, 8'h00, 4'd0, S_SECRET, 1'b0, 1'b0);

    $display("[TB] table round: seven misses then a last-chance win");
    applyStimulus(8'h42);
    cmpBefore = cmpCount;
    applyStimulus(8'hA1);
    checkAll("badGuess", 8'h42, 8'h00, 4'd0, S_GUESS, 1'b0, 1'b0);
    checkOutput("badGuess.cmpPulses", 32'(cmpCount - cmpBefore), 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus.result_i = vecs[i].res;
      pushExp(vecs[i].sw, vecs[i].expAttempts, vecs[i].expState);
      applyStimulus(vecs[i].sw);
    end
    checkAll("lastWin", 8'h42, 8'h42, 4'd8, S_WIN, 1'b1, 1'b0);
    applyStimulus(8'h00);

    $display("[TB] eight misses lose the round");
    applyStimulus(8'h42);
    cmpBefore    = cmpCount;
    bus.result_i = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      pushExp(8'h13, 4'(i), (i == 8) ? S_LOSE : S_GUESS);
      applyStimulus(8'h13);
    end
    repeat (10) @(negedge clk);
    checkOutput("lose.cmpPulses", 32'(cmpCount - cmpBefore), 32'd8);
    checkAll("lose", 8'h42, 8'h13, 4'd8, S_LOSE, 1'b0, 1'b1);
    applyStimulus(8'h13);
    checkAll("loseExit", 8'h42, 8'h00, 4'd0, S_SECRET, 1'b0, 1'b0);

    $display("[TB] long hold gives a single check");
    applyStimulus(8'h42);
    cmpBefore = cmpCount;
    pushExp(8'h13, 4'd1, S_GUESS);
    bus.sw_i    = 8'h13;
    bus.enter_i = 1'b1;
    repeat (20) @(negedge clk);
    bus.enter_i = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("hold.cmpPulses", 32'(cmpCount - cmpBefore), 32'd1);

    $display("[TB] clear beats a simultaneous enter");
    cmpBefore   = cmpCount;
    bus.sw_i    = 8'h55;
    bus.enter_i = 1'b1;
    bus.clear_i = 1'b1;
    repeat (4) @(negedge clk);
    bus.enter_i = 1'b0;
    bus.clear_i = 1'b0;
    repeat (4) @(negedge clk);
    checkAll("clear", 8'h00, 8'h00, 4'd0, S_SECRET, 1'b0, 1'b0);
    checkOutput("clear.cmpPulses", 32'(cmpCount - cmpBefore), 32'd0);

    $display("[TB] reset during CHECK and button held through release");
    applyStimulus(8'h42);
    ignoreCmp   = 1'b1;
    bus.sw_i    = 8'h13;
    bus.enter_i = 1'b1;
    found       = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #2;
      if (bus.state_o == S_CHECK) found = 1'b1;
    end
    checkOutput("midReset.reachedCheck", 32'(found), 32'd1);
    checkOutput("midReset.cmpValid", 32'(bus.cmp_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    checkAll("midReset", 8'h00, 8'h00, 4'd0, S_SECRET, 1'b0, 1'b0);
    checkOutput("midReset.cmpCleared", 32'(bus.cmp_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkAll("heldThroughReset", 8'h00, 8'h00, 4'd0, S_SECRET, 1'b0, 1'b0);
    bus.enter_i = 1'b0;
    repeat (6) @(negedge clk);
    ignoreCmp = 1'b0;
    applyStimulus(8'h42);
    checkAll("rePress", 8'h42, 8'h00, 4'd0, S_GUESS, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("sb.drained", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
